binario_bcd: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It takes the binary result of the multiplier datapath, such as a product of two 2-digit BCD operands (at most 99 × 99 = 9801), and returns packed BCD digits for the display path. It is the return-direction counterpart of the BCD-to-binary input conversion. A start/busy/ready handshake lets the control FSM launch a conversion and wait for a single-cycle completion pulse.

---
 rtl/binario_bcd_if.sv | 28 ++
 rtl/binario_bcd.sv | 110 +++++++++++
 tb/tb_binario_bcd.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/binario_bcd_if.sv
// Start/busy/ready handshake and data lines between the control FSM and the
// binary-to-BCD converter.
interface binario_bcd_if #(
    parameter int ANCHO_BIN = 16,
    parameter int DIGITOS   = 5
);
    logic                   inicio;
    logic [ANCHO_BIN-1:0]   entrada_bin;
    logic                   ocupado;
    logic [4*DIGITOS-1:0]   salida_bcd;
    logic                   bcd_ready;

    modport master (
        output inicio,
        output entrada_bin,
        input  ocupado,
        input  salida_bcd,
        input  bcd_ready
    );

    modport slave (
        input  inicio,
        input  entrada_bin,
        output ocupado,
        output salida_bcd,
        output bcd_ready
    );
endinterface

// File: rtl/binario_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Result is held in salida_bcd; bcd_ready pulses for one cycle on completion.
module binario_bcd #(
    parameter int ANCHO_BIN = 16,
    parameter int DIGITOS   = 5
) (
    input  logic         clk,
    input  logic         rst,
    binario_bcd_if.slave bus
);
    localparam int AW = 4 * DIGITOS;
    localparam int CW = $clog2(ANCHO_BIN + 1);

    function automatic logic [63:0] pot10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_BIN = (64'd1 << ANCHO_BIN) - 64'd1;

    generate
        if (!(pot10(DIGITOS) > MAX_BIN)) begin : g_chk_digitos
            $error("binario_bcd: DIGITOS too small for ANCHO_BIN");
        end
    endgenerate

    // Per-nibble correction applied before each shift; nibbles never carry into each other.
    function automatic logic [AW-1:0] sumar3(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        for (int i = 0; i < DIGITOS; i++) begin
            if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {REPOSO, CORRER, LISTO} estado_t;

    estado_t              r_estado, w_estado;
    logic [ANCHO_BIN-1:0] r_bin, w_bin;
    logic [AW-1:0]        r_acc, w_acc;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [AW-1:0]        r_salida, w_salida;
    logic                 r_ocupado, w_ocupado;
    logic                 r_ready, w_ready;
    logic [AW-1:0]        w_acc_aj;
    logic [AW+ANCHO_BIN-1:0] w_desp;

    always_comb begin
        w_estado = r_estado;
        w_bin    = r_bin;
        w_acc    = r_acc;
        w_cnt    = r_cnt;
        w_salida = r_salida;
        w_acc_aj = sumar3(r_acc);
        w_desp   = {w_acc_aj, r_bin} << 1;

        case (r_estado)
            CORRER: begin
                w_acc = w_desp[AW+ANCHO_BIN-1 -: AW];
                w_bin = w_desp[ANCHO_BIN-1:0];
                w_cnt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_salida = w_desp[AW+ANCHO_BIN-1 -: AW];
                    w_estado = LISTO;
                end
            end
            default: begin
                // REPOSO and LISTO both accept a new start directly.
                if (bus.inicio) begin
                    w_bin    = bus.entrada_bin;
                    w_acc    = '0;
                    w_cnt    = CW'(ANCHO_BIN);
                    w_estado = CORRER;
                end else begin
                    w_estado = REPOSO;
                end
            end
        endcase

        w_ocupado = (w_estado == CORRER);
        w_ready   = (w_estado == LISTO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= REPOSO;
            r_bin     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_salida  <= '0;
            r_ocupado <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_estado  <= w_estado;
            r_bin     <= w_bin;
            r_acc     <= w_acc;
            r_cnt     <= w_cnt;
            r_salida  <= w_salida;
            r_ocupado <= w_ocupado;
            r_ready   <= w_ready;
        end
    end

    assign bus.ocupado    = r_ocupado;
    assign bus.bcd_ready  = r_ready;
    assign bus.salida_bcd = r_salida;
endmodule

// File: tb/tb_binario_bcd.sv
// Self-checking bench for binario_bcd: decimal-arithmetic reference model with a
// per-cycle compare, plus directed conversions with literal expected results.
module tb_binario_bcd;
    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    binario_bcd_if #(.ANCHO_BIN(16), .DIGITOS(5)) bus ();

    binario_bcd #(.ANCHO_BIN(16), .DIGITOS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: a conversion takes 16 edges after capture, result via decimal division.
    int          m_left;
    logic        m_ready;
    logic [19:0] m_out;
    logic [15:0] m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_ready <= 1'b0;
            m_out   <= '0;
            m_val   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_out   <= to_bcd(32'(m_val));
                m_ready <= 1'b1;
            end
        end else begin
            m_ready <= 1'b0;
            if (bus.inicio) begin
                m_val  <= bus.entrada_bin;
                m_left <= 16;
            end
        end
    end

    always @(negedge clk) begin
        logic nib_ok;
        chk("ocupado_model", 32'(bus.ocupado), 32'(m_left > 0));
        chk("ready_model", 32'(bus.bcd_ready), 32'(m_ready));
        chk("salida_model", 32'(bus.salida_bcd), 32'(m_out));
        nib_ok = 1'b1;
        for (int i = 0; i < 5; i++) if (bus.salida_bcd[4*i +: 4] > 4'd9) nib_ok = 1'b0;
        chk("nibbles_le_9", 32'(nib_ok), 32'd1);
        chk("busy_ready_excl", 32'(bus.ocupado & bus.bcd_ready), 32'd0);
    end

    // Drive a start at a falling edge; returns half a cycle after the capture edge.
    task automatic start(input logic [15:0] v);
        @(negedge clk);
        bus.inicio      = 1'b1;
        bus.entrada_bin = v;
        @(negedge clk);
        bus.inicio      = 1'b0;
        bus.entrada_bin = 16'($urandom);
    endtask

    task automatic wait_ready(output int n, output int busy);
        n    = 0;
        busy = 0;
        while (!bus.bcd_ready && n < 40) begin
            if (bus.ocupado) busy++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic convert(input logic [15:0] v, input logic [19:0] exp, input string name);
        int n, busy;
        start(v);
        wait_ready(n, busy);
        chk({name, "_latency"}, 32'(n), 32'd16);
        chk({name, "_busy_cycles"}, 32'(busy), 32'd16);
        chk({name, "_result"}, 32'(bus.salida_bcd), 32'(exp));
    endtask

    int n, busy, pulses;

    initial begin
        rst             = 1'b0;
        bus.inicio      = 1'b0;
        bus.entrada_bin = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_ready", 32'(bus.bcd_ready), 32'd0);
        chk("rst_salida", 32'(bus.salida_bcd), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.inicio      = 1'($urandom);
            bus.entrada_bin = 16'($urandom);
            #1;
            chk("rst_hold_ocupado", 32'(bus.ocupado), 32'd0);
            chk("rst_hold_salida", 32'(bus.salida_bcd), 32'd0);
        end
        bus.inicio = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        convert(16'd0, 20'h00000, "val_0");
        convert(16'd9, 20'h00009, "val_9");
        convert(16'd10, 20'h00010, "val_10");
        convert(16'd9801, 20'h09801, "prod_9801");
        convert(16'd65535, 20'h65535, "max_65535");
        convert(16'd1000, 20'h01000, "prod_1000");

        // Start request during a conversion must be ignored.
        start(16'd1234);
        repeat (4) @(negedge clk);
        bus.inicio      = 1'b1;
        bus.entrada_bin = 16'd4321;
        @(negedge clk);
        bus.inicio = 1'b0;
        wait_ready(n, busy);
        chk("ignored_latency", 32'(n), 32'd11);
        chk("ignored_result", 32'(bus.salida_bcd), 32'h01234);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.bcd_ready) pulses++;
            if (bus.ocupado) pulses++;
        end
        chk("ignored_no_second", 32'(pulses), 32'd0);

        // Back-to-back: restart during the LISTO cycle.
        start(16'd42);
        wait_ready(n, busy);
        chk("b2b_first_latency", 32'(n), 32'd16);
        chk("b2b_first_result", 32'(bus.salida_bcd), 32'h00042);
        bus.inicio      = 1'b1;
        bus.entrada_bin = 16'd77;
        @(negedge clk);
        bus.inicio = 1'b0;
        chk("b2b_reassert", 32'(bus.ocupado), 32'd1);
        chk("b2b_hold_old", 32'(bus.salida_bcd), 32'h00042);
        wait_ready(n, busy);
        chk("b2b_second_latency", 32'(n), 32'd16);
        chk("b2b_second_result", 32'(bus.salida_bcd), 32'h00077);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a conversion.
        start(16'd5555);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("midrst_ready", 32'(bus.bcd_ready), 32'd0);
        chk("midrst_salida", 32'(bus.salida_bcd), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.bcd_ready) pulses++;
        end
        chk("midrst_no_ready", 32'(pulses), 32'd0);
        convert(16'd321, 20'h00321, "after_rst_321");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
